// File: rtl/dma_ci_engine.sv
`default_nettype none
// ============================================================================
// Module   : dma_ci_engine
// Brief    : Custom-instruction driven DMA engine. Moves blocks between a
//            local 32-bit memory and the system bus in bursts. CI accesses
//            reach the local memory and the DMA control registers.
// Options  : DMA_CI_IRQ_EN - adds the irq output (completion/error interrupt)
// Revision : 1.0 - initial release
// ============================================================================
module dma_ci_engine #(
  parameter logic [7:0] CUSTOM_ID = 8'h00,
  parameter int         MEM_AW    = 9,
  parameter int         MAX_BURST = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result,
  output logic        requestTransaction,
  input  logic        transactionGranted,
  output logic        beginTransactionOut,
  output logic [31:0] addressDataOut,
  output logic [7:0]  burstSizeOut,
  output logic        readNotWriteOut,
  output logic        dataValidOut,
  output logic        endTransactionOut,
  input  logic [31:0] addressDataIn,
  input  logic        dataValidIn,
  input  logic        endTransactionIn,
`ifdef DMA_CI_IRQ_EN
  output logic        irq,
`endif
  input  logic        busErrorIn
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    REQUEST     = 3'd1,
    BEGIN       = 3'd2,
    READ_BEATS  = 3'd3,
    WRITE_BEATS = 3'd4,
    WRITE_END   = 3'd5
  } state_t;

  localparam logic [10:0] c_max_burst = 11'(MAX_BURST);

  state_t              r_state, w_state_next;
  logic [31:0]         r_mem [0:(2**MEM_AW)-1];
  logic [31:0]         r_bus_addr;
  logic [MEM_AW-1:0]   r_local_addr;
  logic [9:0]          r_block_size;
  logic [7:0]          r_burst_size;
  logic                r_dir;
  logic                r_error, r_complete;
  logic [10:0]         r_remaining, r_len, r_cnt;
  logic [31:0]         r_wdata, r_ci_mem_q, r_rd_val;
  logic                r_rd_pend;
  logic [2:0]          r_rd_sel;

  logic                w_ci_sel, w_ci_we, w_ci_re, w_cfg_we, w_launch, w_start_xfer;
  logic                w_mem_ci_we, w_dma_we, w_prefetch, w_busy, w_abort;
  logic                w_burst_end, w_last_burst;
  logic [2:0]          w_reg;
  logic [MEM_AW-1:0]   w_ci_addr;
  logic [10:0]         w_plus1, w_len_a, w_len, w_len_m1, w_rem_after;
  logic [31:0]         w_reg_rdata;
  logic                w_unused;

  assign w_ci_sel     = start && (ciN == CUSTOM_ID);
  assign w_ci_we      = w_ci_sel && valueA[9];
  assign w_ci_re      = w_ci_sel && !valueA[9];
  assign w_reg        = valueA[12:10];
  assign w_ci_addr    = valueA[MEM_AW-1:0];
  assign w_busy       = (r_state != IDLE);
  // Configuration registers are frozen while a transfer is running.
  assign w_cfg_we     = w_ci_we && !w_busy;
  assign w_launch     = w_cfg_we && (w_reg == 3'd5) && valueB[0];
  assign w_start_xfer = w_launch && (r_block_size != 10'd0);
  assign w_mem_ci_we  = w_ci_we && (w_reg == 3'd0);
  assign w_dma_we     = (r_state == READ_BEATS) && dataValidIn;
  // Write data is fetched one cycle before the beat that drives it.
  assign w_prefetch   = ((r_state == BEGIN) && r_dir) ||
                        ((r_state == WRITE_BEATS) && ((r_cnt + 11'd1) < r_len));
  assign w_abort      = busErrorIn && w_busy;

  // Burst length is the smallest of programmed size, engine limit and words left.
  assign w_plus1      = {3'b000, r_burst_size} + 11'd1;
  assign w_len_a      = (w_plus1 < c_max_burst) ? w_plus1 : c_max_burst;
  assign w_len        = (w_len_a < r_remaining) ? w_len_a : r_remaining;
  assign w_len_m1     = r_len - 11'd1;
  assign w_rem_after  = r_remaining - r_len;
  assign w_last_burst = (w_rem_after == 11'd0);

  assign w_unused     = &{1'b0, valueA, w_len_m1[10:8]};

  // Register read mux for the CI read path.
  always_comb begin
    w_reg_rdata = 32'd0;
    case (w_reg)
      3'd1:    w_reg_rdata = r_bus_addr;
      3'd2:    w_reg_rdata = {{(32-MEM_AW){1'b0}}, r_local_addr};
      3'd3:    w_reg_rdata = {22'd0, r_block_size};
      3'd4:    w_reg_rdata = {24'd0, r_burst_size};
      3'd5:    w_reg_rdata = {29'd0, r_complete, r_error, w_busy};
      default: w_reg_rdata = 32'd0;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic and bus outputs; a bus error forces IDLE from any state.
  always_comb begin
    w_state_next        = r_state;
    requestTransaction  = 1'b0;
    beginTransactionOut = 1'b0;
    addressDataOut      = 32'd0;
    burstSizeOut        = 8'd0;
    readNotWriteOut     = 1'b0;
    dataValidOut        = 1'b0;
    endTransactionOut   = 1'b0;
    w_burst_end         = 1'b0;
    case (r_state)
      IDLE: if (w_start_xfer) w_state_next = REQUEST;
      REQUEST: begin
        requestTransaction = 1'b1;
        if (transactionGranted) w_state_next = BEGIN;
      end
      BEGIN: begin
        beginTransactionOut = 1'b1;
        addressDataOut      = r_bus_addr;
        burstSizeOut        = w_len_m1[7:0];
        readNotWriteOut     = !r_dir;
        w_state_next        = r_dir ? WRITE_BEATS : READ_BEATS;
      end
      READ_BEATS: begin
        if (endTransactionIn) begin
          w_burst_end  = 1'b1;
          w_state_next = w_last_burst ? IDLE : REQUEST;
        end
      end
      WRITE_BEATS: begin
        dataValidOut   = 1'b1;
        addressDataOut = r_wdata;
        if (r_cnt == w_len_m1) w_state_next = WRITE_END;
      end
      WRITE_END: begin
        endTransactionOut = 1'b1;
        w_burst_end       = 1'b1;
        w_state_next      = w_last_burst ? IDLE : REQUEST;
      end
      default: w_state_next = IDLE;
    endcase
    if (w_abort) w_state_next = IDLE;
  end

  // Control registers, transfer bookkeeping and status.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_bus_addr   <= 32'd0;
      r_local_addr <= '0;
      r_block_size <= 10'd0;
      r_burst_size <= 8'd0;
      r_dir        <= 1'b0;
      r_error      <= 1'b0;
      r_complete   <= 1'b0;
      r_remaining  <= 11'd0;
      r_len        <= 11'd0;
      r_cnt        <= 11'd0;
    end else begin
      if (w_cfg_we) begin
        case (w_reg)
          3'd1:    r_bus_addr   <= {valueB[31:2], 2'b00};
          3'd2:    r_local_addr <= valueB[MEM_AW-1:0];
          3'd3:    r_block_size <= valueB[9:0];
          3'd4:    r_burst_size <= valueB[7:0];
          3'd5:    r_dir        <= valueB[1];
          default: ;
        endcase
      end
      if (w_launch) begin
        r_error     <= 1'b0;
        r_complete  <= (r_block_size == 10'd0);
        r_remaining <= {1'b0, r_block_size};
      end
      if ((r_state == REQUEST) && transactionGranted) r_len <= w_len;
      if (r_state == BEGIN)       r_cnt <= 11'd0;
      if (r_state == WRITE_BEATS) r_cnt <= r_cnt + 11'd1;
      if (w_prefetch || w_dma_we) r_local_addr <= r_local_addr + 1'b1;
      if (w_burst_end && !w_abort) begin
        r_bus_addr  <= r_bus_addr + {19'd0, r_len, 2'b00};
        r_remaining <= w_rem_after;
        if (w_last_burst) r_complete <= 1'b1;
      end
      if (w_abort) r_error <= 1'b1;
    end
  end

  // Local memory; the CI write is issued last so it wins a same-word collision.
  always_ff @(posedge clock) begin
    if (w_dma_we)    r_mem[r_local_addr] <= addressDataIn;
    if (w_mem_ci_we) r_mem[w_ci_addr]    <= valueB;
    if (w_prefetch)  r_wdata             <= r_mem[r_local_addr];
    r_ci_mem_q <= r_mem[w_ci_addr];
  end

  // CI handshake: writes finish after one cycle, reads after two.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_pend <= 1'b0;
      r_rd_sel  <= 3'd0;
      r_rd_val  <= 32'd0;
      done      <= 1'b0;
      result    <= 32'd0;
    end else begin
      r_rd_pend <= w_ci_re;
      r_rd_sel  <= w_reg;
      r_rd_val  <= w_reg_rdata;
      done      <= w_ci_we || r_rd_pend;
      result    <= r_rd_pend ? ((r_rd_sel == 3'd0) ? r_ci_mem_q : r_rd_val) : 32'd0;
    end
  end

`ifdef DMA_CI_IRQ_EN
  logic r_irq;
  logic w_irq_set;

  assign w_irq_set = w_abort || (w_burst_end && w_last_burst) ||
                     (w_launch && (r_block_size == 10'd0));

  // Interrupt latches on completion or error and is acknowledged by a control write.
  always_ff @(posedge clock) begin
    if (reset)                                r_irq <= 1'b0;
    else if (w_irq_set)                       r_irq <= 1'b1;
    else if (w_ci_we && (w_reg == 3'd5))      r_irq <= 1'b0;
  end

  assign irq = r_irq;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dma_ci_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_ci_engine
// Brief    : Directed self-checking bench for dma_ci_engine (CI access, bus
//            read/write bursts, address wrap, bus error, reset mid-burst).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_ci_engine;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  ciN = 8'h00;
  logic [31:0] valueA = 32'd0;
  logic [31:0] valueB = 32'd0;
  logic        done;
  logic [31:0] result;
  logic        requestTransaction;
  logic        transactionGranted = 1'b0;
  logic        beginTransactionOut;
  logic [31:0] addressDataOut;
  logic [7:0]  burstSizeOut;
  logic        readNotWriteOut;
  logic        dataValidOut;
  logic        endTransactionOut;
  logic [31:0] addressDataIn = 32'd0;
  logic        dataValidIn = 1'b0;
  logic        endTransactionIn = 1'b0;
  logic        busErrorIn = 1'b0;
`ifdef DMA_CI_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;

  dma_ci_engine dut (
    .clock               (clock),
    .reset               (reset),
    .start               (start),
    .ciN                 (ciN),
    .valueA              (valueA),
    .valueB              (valueB),
    .done                (done),
    .result              (result),
    .requestTransaction  (requestTransaction),
    .transactionGranted  (transactionGranted),
    .beginTransactionOut (beginTransactionOut),
    .addressDataOut      (addressDataOut),
    .burstSizeOut        (burstSizeOut),
    .readNotWriteOut     (readNotWriteOut),
    .dataValidOut        (dataValidOut),
    .endTransactionOut   (endTransactionOut),
    .addressDataIn       (addressDataIn),
    .dataValidIn         (dataValidIn),
    .endTransactionIn    (endTransactionIn),
`ifdef DMA_CI_IRQ_EN
    .irq                 (irq),
`endif
    .busErrorIn          (busErrorIn)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic ci_write(input logic [2:0] sel, input logic [8:0] addr, input logic [31:0] data);
    start  = 1'b1;
    valueA = {19'd0, sel, 1'b1, addr};
    valueB = data;
    tick();
    start  = 1'b0;
    valueA = 32'd0;
    valueB = 32'd0;
    check("wr_done", 32'(done), 32'd1);
  endtask

  task automatic ci_read(input logic [2:0] sel, input logic [8:0] addr, output logic [31:0] data);
    start  = 1'b1;
    valueA = {19'd0, sel, 1'b0, addr};
    tick();
    start  = 1'b0;
    valueA = 32'd0;
    check("rd_done_p1", 32'(done), 32'd0);
    tick();
    check("rd_done_p2", 32'(done), 32'd1);
    data = result;
  endtask

  task automatic wait_req;
    int n = 0;
    while (!requestTransaction && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", 32'(requestTransaction), 32'd1);
  endtask

  task automatic grant;
    transactionGranted = 1'b1;
    tick();
    transactionGranted = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int          lens [3];
    int          k;
    lens = '{8, 8, 4};

    // Reset state
    tick();
    tick();
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_req", 32'(requestTransaction), 32'd0);
    reset = 1'b0;
    tick();

    // CI write / read of local word 5
    ci_write(3'd0, 9'd5, 32'hDEADBEEF);
    ci_read(3'd0, 9'd5, d);
    check("ci_rdback", d, 32'hDEADBEEF);
    ci_read(3'd6, 9'd0, d);
    check("reg6_zero", d, 32'd0);

    // Bus -> local, block 20, burst size 7, bus 0x1000, local 16
    ci_write(3'd1, 9'd0, 32'h0000_1000);
    ci_write(3'd2, 9'd0, 32'd16);
    ci_write(3'd3, 9'd0, 32'd20);
    ci_write(3'd4, 9'd0, 32'd7);
    ci_write(3'd5, 9'd0, 32'h1);
    k = 0;
    for (int b = 0; b < 3; b++) begin
      wait_req();
      grant();
      check("rd_begin", 32'(beginTransactionOut), 32'd1);
      check("rd_addr", addressDataOut, 32'h1000 + 32'(b) * 32'h20);
      check("rd_bsize", 32'(burstSizeOut), 32'(lens[b] - 1));
      check("rd_rnw", 32'(readNotWriteOut), 32'd1);
      tick();
      for (int i = 0; i < lens[b]; i++) begin
        dataValidIn      = 1'b1;
        addressDataIn    = 32'hA000_0000 + 32'(k);
        endTransactionIn = (i == lens[b] - 1);
        k++;
        tick();
      end
      dataValidIn      = 1'b0;
      endTransactionIn = 1'b0;
      addressDataIn    = 32'd0;
    end
    check("rd_req_idle", 32'(requestTransaction), 32'd0);
    ci_read(3'd5, 9'd0, d);
    check("rd_status", d, 32'h4);
    ci_read(3'd0, 9'd16, d);
    check("mem16", d, 32'hA000_0000);
    ci_read(3'd0, 9'd23, d);
    check("mem23", d, 32'hA000_0007);
    ci_read(3'd0, 9'd24, d);
    check("mem24", d, 32'hA000_0008);
    ci_read(3'd0, 9'd35, d);
    check("mem35", d, 32'hA000_0013);

    // Local -> bus, block 3, local start 510 wraps to 0
    ci_write(3'd0, 9'd510, 32'h1111_1111);
    ci_write(3'd0, 9'd511, 32'h2222_2222);
    ci_write(3'd0, 9'd0,   32'h3333_3333);
    ci_write(3'd1, 9'd0, 32'h0000_2000);
    ci_write(3'd2, 9'd0, 32'd510);
    ci_write(3'd3, 9'd0, 32'd3);
    ci_write(3'd4, 9'd0, 32'd15);
    ci_write(3'd5, 9'd0, 32'h3);
    wait_req();
    grant();
    check("wr_begin", 32'(beginTransactionOut), 32'd1);
    check("wr_addr", addressDataOut, 32'h2000);
    check("wr_bsize", 32'(burstSizeOut), 32'd2);
    check("wr_rnw", 32'(readNotWriteOut), 32'd0);
    tick();
    check("wr_dv0", 32'(dataValidOut), 32'd1);
    check("wr_d0", addressDataOut, 32'h1111_1111);
    tick();
    check("wr_d1", addressDataOut, 32'h2222_2222);
    tick();
    check("wr_dv2", 32'(dataValidOut), 32'd1);
    check("wr_d2", addressDataOut, 32'h3333_3333);
    check("wr_end_early", 32'(endTransactionOut), 32'd0);
    tick();
    check("wr_end", 32'(endTransactionOut), 32'd1);
    check("wr_dv_end", 32'(dataValidOut), 32'd0);
    tick();
    check("wr_end_drop", 32'(endTransactionOut), 32'd0);
    ci_read(3'd5, 9'd0, d);
    check("wr_status", d, 32'h4);
    ci_read(3'd2, 9'd0, d);
    check("wr_local_wrap", d, 32'd1);

    // Bus error during second read beat; config writes ignored while busy
    ci_write(3'd1, 9'd0, 32'h0000_3000);
    ci_write(3'd2, 9'd0, 32'd40);
    ci_write(3'd3, 9'd0, 32'd4);
    ci_write(3'd4, 9'd0, 32'd7);
    ci_write(3'd5, 9'd0, 32'h1);
    ci_read(3'd5, 9'd0, d);
    check("busy_status", d, 32'h1);
    ci_write(3'd1, 9'd0, 32'hFFFF_0000);
    wait_req();
    grant();
    tick();
    dataValidIn   = 1'b1;
    addressDataIn = 32'h5555_0000;
    tick();
    busErrorIn    = 1'b1;
    addressDataIn = 32'h5555_0001;
    tick();
    busErrorIn    = 1'b0;
    dataValidIn   = 1'b0;
    addressDataIn = 32'd0;
    check("err_req", 32'(requestTransaction), 32'd0);
    check("err_begin", 32'(beginTransactionOut), 32'd0);
    check("err_data", addressDataOut, 32'd0);
    check("err_dv", 32'(dataValidOut), 32'd0);
    ci_read(3'd5, 9'd0, d);
    check("err_status", d, 32'h2);
`ifdef DMA_CI_IRQ_EN
    check("err_irq", 32'(irq), 32'd1);
`endif
    ci_read(3'd1, 9'd0, d);
    check("busy_wr_ignored", d, 32'h3000);

    // Zero-length block completes without a bus request and clears error
    ci_write(3'd3, 9'd0, 32'd0);
    ci_write(3'd5, 9'd0, 32'h1);
    check("zero_noreq", 32'(requestTransaction), 32'd0);
    tick();
    check("zero_noreq2", 32'(requestTransaction), 32'd0);
    ci_read(3'd5, 9'd0, d);
    check("zero_status", d, 32'h4);

    // Reset in the middle of a write burst, then a fresh transfer
    ci_write(3'd1, 9'd0, 32'h0000_4000);
    ci_write(3'd2, 9'd0, 32'd0);
    ci_write(3'd3, 9'd0, 32'd4);
    ci_write(3'd4, 9'd0, 32'd3);
    ci_write(3'd5, 9'd0, 32'h3);
    wait_req();
    grant();
    check("rs_begin_addr", addressDataOut, 32'h4000);
    tick();
    check("rs_dv", 32'(dataValidOut), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rs_dv_drop", 32'(dataValidOut), 32'd0);
    check("rs_data_drop", addressDataOut, 32'd0);
    check("rs_req_drop", 32'(requestTransaction), 32'd0);
    check("rs_done", 32'(done), 32'd0);
    ci_read(3'd1, 9'd0, d);
    check("rs_reg1", d, 32'd0);
    ci_read(3'd5, 9'd0, d);
    check("rs_status", d, 32'd0);
    ci_write(3'd1, 9'd0, 32'h0000_5000);
    ci_write(3'd2, 9'd0, 32'd510);
    ci_write(3'd3, 9'd0, 32'd2);
    ci_write(3'd4, 9'd0, 32'd3);
    ci_write(3'd5, 9'd0, 32'h3);
    wait_req();
    grant();
    check("rs2_addr", addressDataOut, 32'h5000);
    check("rs2_bsize", 32'(burstSizeOut), 32'd1);
    tick();
    check("rs2_d0", addressDataOut, 32'h1111_1111);
    tick();
    check("rs2_d1", addressDataOut, 32'h2222_2222);
    tick();
    check("rs2_end", 32'(endTransactionOut), 32'd1);
    tick();
    ci_read(3'd5, 9'd0, d);
    check("rs2_status", d, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
